vga_line_scanner: RTL and testbench
===================================

Name: vga_line_scanner

Overview:
- Parametrised VGA scan engine, the next-generation replacement for the fixed 640x480 line-fetch controller.
- Generates H/V timing from a pixel-enable strobe, prefetches one VRAM line per scanline over a req/ack handshake, and serialises it into 3/3/2 RGB.
- Supports 1 bpp mono (fg/bg colours) and 8 bpp direct colour, optional line doubling, and sync polarity selection.
- Sits between the clock divider (pix_ce), the dual-port VRAM read port and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
BPP, 1, bits per pixel; legal values are 1 or 8
ROW_SHIFT, 0, VRAM row = visible line >> ROW_SHIFT (1 = line doubling)
ADDR_W, 9, VRAM row address width
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clk  in  1  system clock; all logic on rising edge
clr  in  1  synchronous, active-high reset
pix_ce  in  1  one-clk pixel enable; all timing advances only when high
mono_fg  in  8  RRRGGGBB foreground colour (BPP=1)
mono_bg  in  8  RRRGGGBB background colour (BPP=1)
vram_req  out  1  line fetch request, level
vram_addr  out  ADDR_W  row address; stable while vram_req high
vram_ack  in  1  one-clk pulse; vram_data valid in that cycle
vram_data  in  H_ACTIVE*BPP  line data; pixel 0 in LSBs
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
red  out  3  red
grn  out  3  green
blu  out  2  blue
frame_start  out  1  one-clk pulse when pix_ce and h=0,v=0
underrun  out  1  sticky; a line started without its fetch complete

Behaviour:
- Reset: h_cnt=0, v_cnt=0, FSM=IDLE, vram_req=0, vram_addr=0, hsync=vsync=~SYNC_POL, red/grn/blu=0, frame_start=0, underrun=0, both line buffers=0, shadow_valid=0. Reset is honoured mid-fetch; a later ack is ignored because the FSM is in IDLE.
- Counters advance on pix_ce. h_cnt counts 0..H_TOT-1, where H_TOT = sum of the H_* parameters. v_cnt increments when h_cnt wraps, 0..V_TOT-1. Both wrap to 0.
- hsync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on v.
- All pixel outputs are registered: outputs correspond to the counter value one pix_ce earlier (1 pix_ce latency). Syncs are delayed identically so they stay aligned with colour.
- Fetch target (nv = next visible line):
  - If v < V_ACTIVE-1: nv = v+1.
  - If v = V_TOT-1: nv = 0.
  - Otherwise: no fetch.
- Fetch FSM:
  - IDLE -> REQ on the pix_ce cycle where h_cnt = H_ACTIVE and a fetch target exists. Set vram_addr = nv>>ROW_SHIFT.
  - REQ holds vram_req=1 until vram_ack. On ack: capture vram_data into the shadow buffer, set shadow_valid=1, deassert req, go to IDLE.
  - If nv>>ROW_SHIFT equals the current row, the fetch is still issued (no skip optimisation).
- Line start (pix_ce, h wraps to 0, new v visible):
  - If shadow_valid: shadow -> active buffer, shadow_valid=0.
  - Else: set underrun=1 and force the active buffer to 0 for that line. If the FSM is still in REQ, it is abandoned (req dropped).
- Visible region (h<H_ACTIVE and v<V_ACTIVE):
  - BPP=1: active bit h selects mono_fg (1) or mono_bg (0).
  - BPP=8: active byte h is the colour directly.
  - Colour bits 7:5 -> red, 4:2 -> grn, 1:0 -> blu.
- Outside the visible region: red/grn/blu=0.
- underrun is cleared only by clr.
- Simultaneous ack and line start in the same clk: the ack wins; data transfers straight to active with no underrun.

Decomposition:
- Package vga_pkg holds the colour index constants (R_MSB=7, G_MSB=4, B_MSB=1) and the standard 640x480@60 timing constants used as defaults.
- One natural sub-module: vga_timing_gen (h/v counters, syncs, visible flag, frame_start).
- Fetch FSM and line buffers stay in the top.

Test Plan:
- clr high 3 cycles then low, pix_ce every 2nd clk -> all outputs 0, syncs high after reset. frame_start pulses once every 800*525 pix_ce cycles. hsync low for exactly 96 pix_ce.
- BPP=1, VRAM model acks 3 clk after req with pattern 0xAAAA..., fg=0xFF, bg=0x00 -> visible pixels alternate 7/7/3 and 0, starting with bg at h=0. underrun=0.
- VRAM model never acks line 5 -> line 5 shows bg only, underrun=1 and stays set. Line 6 displays correctly.
- BPP=8, ROW_SHIFT=1 -> vram_addr sequence 0,0,1,1,2... across visible lines. Byte 0x1C at pixel 3 gives red=0, grn=7, blu=0.
- Ack arriving on the same clk as line start -> correct line displayed, underrun=0.
- Assert clr during REQ, then ack arrives 2 clk later -> ack ignored, vram_req=0, outputs at reset values.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan engine: RRRGGGBB field positions,
// 640x480@60 default timing and the line-fetch state encoding.
package vga_pkg;

  localparam int R_MSB = 7;
  localparam int G_MSB = 4;
  localparam int B_MSB = 1;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] grn;
    logic [1:0] blu;
  } rgb332_t;

  function automatic rgb332_t split_rgb(input logic [7:0] colour);
    rgb332_t pix;
    pix.red = colour[R_MSB -: 3];
    pix.grn = colour[G_MSB -: 3];
    pix.blu = colour[B_MSB -: 2];
    return pix;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// H/V scan counters advanced by pix_ce, registered syncs and frame_start,
// plus the combinational visible flag and line-start strobe used by the fetch logic.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0,
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W   = $clog2(H_TOT),
  localparam int V_W   = $clog2(V_TOT)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           pix_ce,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           visible,
  output logic           line_start,
  output logic           hsync,
  output logic           vsync,
  output logic           frame_start
);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic           h_wrap;
  logic           v_wrap;
  logic [V_W-1:0] v_next;
  logic           hs_act;
  logic           vs_act;

  assign h_wrap  = (int'(h_cnt) == H_TOT - 1);
  assign v_wrap  = (int'(v_cnt) == V_TOT - 1);
  assign v_next  = v_wrap ? '0 : v_cnt + 1'b1;
  assign visible = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hs_act  = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
  assign vs_act  = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);

  // Fires on the pix_ce that wraps h into a visible line.
  assign line_start = pix_ce && h_wrap && (int'(v_next) < V_ACTIVE);

  always_ff @(posedge clk) begin
    if (clr) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && (h_cnt == '0) && (v_cnt == '0);
      if (pix_ce) begin
        hsync <= hs_act ? SYNC_POL : ~SYNC_POL;
        vsync <= vs_act ? SYNC_POL : ~SYNC_POL;
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) begin
          v_cnt <= v_next;
        end
      end
    end
  end

endmodule

// File: rtl/vga_line_scanner.sv
// VGA scan engine: prefetches one VRAM row per scanline into a shadow buffer,
// swaps it in at line start and serialises it as registered 3/3/2 RGB.
//
// state   | meaning
// ST_IDLE | no fetch outstanding
// ST_REQ  | vram_req high, waiting for vram_ack
module vga_line_scanner
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int BPP       = 1,
  parameter int ROW_SHIFT = 0,
  parameter int ADDR_W    = 9,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    pix_ce,
  input  logic [7:0]              mono_fg,
  input  logic [7:0]              mono_bg,
  output logic                    vram_req,
  output logic [ADDR_W-1:0]       vram_addr,
  input  logic                    vram_ack,
  input  logic [H_ACTIVE*BPP-1:0] vram_data,
  output logic                    hsync,
  output logic                    vsync,
  output logic [2:0]              red,
  output logic [2:0]              grn,
  output logic [1:0]              blu,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W    = $clog2(H_TOT);
  localparam int V_W    = $clog2(V_TOT);
  localparam int LINE_W = H_ACTIVE * BPP;
  localparam int IDX_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  logic [H_W-1:0]    h_cnt;
  logic [V_W-1:0]    v_cnt;
  logic              visible;
  logic              line_start;
  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic              has_target;
  logic [V_W-1:0]    target_line;
  logic              fetch_start;
  logic              ack_take;
  logic [LINE_W-1:0] shadow_buf;
  logic [LINE_W-1:0] active_buf;
  logic              shadow_valid;
  logic [IDX_W-1:0]  h_idx;
  logic [7:0]        pix_colour;
  rgb332_t           pix_rgb;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk         (clk),
    .clr         (clr),
    .pix_ce      (pix_ce),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .visible     (visible),
    .line_start  (line_start),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  // The last visible line has nothing to prefetch; the final blank line prefetches line 0.
  always_comb begin
    has_target  = 1'b0;
    target_line = '0;
    if (int'(v_cnt) < V_ACTIVE - 1) begin
      has_target  = 1'b1;
      target_line = v_cnt + 1'b1;
    end else if (int'(v_cnt) == V_TOT - 1) begin
      has_target  = 1'b1;
    end
  end

  assign fetch_start = pix_ce && (int'(h_cnt) == H_ACTIVE) && has_target;
  assign ack_take    = vram_ack && (state_q == ST_REQ);
  assign vram_req    = (state_q == ST_REQ);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fetch_start) state_d = ST_REQ;
      ST_REQ:  if (ack_take || line_start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vram_addr <= '0;
    end else if (state_q == ST_IDLE && fetch_start) begin
      vram_addr <= ADDR_W'(target_line >> ROW_SHIFT);
    end
  end

  // A late fetch blanks the line instead of showing stale data.
  always_ff @(posedge clk) begin
    if (clr) begin
      shadow_buf   <= '0;
      active_buf   <= '0;
      shadow_valid <= 1'b0;
      underrun     <= 1'b0;
    end else if (line_start) begin
      if (ack_take) begin
        active_buf <= vram_data;
      end else if (shadow_valid) begin
        active_buf   <= shadow_buf;
        shadow_valid <= 1'b0;
      end else begin
        active_buf <= '0;
        underrun   <= 1'b1;
      end
    end else if (ack_take) begin
      shadow_buf   <= vram_data;
      shadow_valid <= 1'b1;
    end
  end

  assign h_idx = h_cnt[IDX_W-1:0];

  generate
    if (BPP == 1) begin : g_mono
      assign pix_colour = active_buf[h_idx] ? mono_fg : mono_bg;
    end else begin : g_direct
      assign pix_colour = active_buf[h_idx*8 +: 8];
    end
  endgenerate

  assign pix_rgb = split_rgb(pix_colour);

  always_ff @(posedge clk) begin
    if (clr) begin
      red <= '0;
      grn <= '0;
      blu <= '0;
    end else if (pix_ce) begin
      if (visible) begin
        red <= pix_rgb.red;
        grn <= pix_rgb.grn;
        blu <= pix_rgb.blu;
      end else begin
        red <= '0;
        grn <= '0;
        blu <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_line_scanner.sv
// Randomised bench for vga_line_scanner: a mono/no-doubling instance and an
// 8bpp/line-doubled/active-high-sync instance checked against a frame-level model.
module tb_vga_line_scanner;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic clr;
  logic pix_ce;
  logic [7:0] mono_fg, mono_bg;
  logic [15:0]  vram_data_a;
  logic [127:0] vram_data_b;
  logic         ack_i [2];
  logic          req_o  [2];
  logic [AW-1:0] addr_o [2];
  logic          hs_o   [2];
  logic          vs_o   [2];
  logic [2:0]    red_o  [2];
  logic [2:0]    grn_o  [2];
  logic [1:0]    blu_o  [2];
  logic          fs_o   [2];
  logic          ur_o   [2];

  always #5 clk = ~clk;

  vga_line_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BPP(1), .ROW_SHIFT(0), .ADDR_W(AW), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .clr(clr), .pix_ce(pix_ce), .mono_fg(mono_fg), .mono_bg(mono_bg),
    .vram_req(req_o[0]), .vram_addr(addr_o[0]), .vram_ack(ack_i[0]), .vram_data(vram_data_a),
    .hsync(hs_o[0]), .vsync(vs_o[0]), .red(red_o[0]), .grn(grn_o[0]), .blu(blu_o[0]),
    .frame_start(fs_o[0]), .underrun(ur_o[0])
  );

  vga_line_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BPP(8), .ROW_SHIFT(1), .ADDR_W(AW), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .clr(clr), .pix_ce(pix_ce), .mono_fg(mono_fg), .mono_bg(mono_bg),
    .vram_req(req_o[1]), .vram_addr(addr_o[1]), .vram_ack(ack_i[1]), .vram_data(vram_data_b),
    .hsync(hs_o[1]), .vsync(vs_o[1]), .red(red_o[1]), .grn(grn_o[1]), .blu(blu_o[1]),
    .frame_start(fs_o[1]), .underrun(ur_o[1])
  );

  int checks = 0;
  int failures = 0;

  // Reference model: scan position, per-instance line contents and fetch status.
  int m_h, m_v, pix_idx, px_h, px_v;
  logic px_ce;
  logic m_req [2], m_req_prev [2], m_fetched [2], m_ur [2];
  logic [127:0] m_fdata [2], m_active [2];
  logic [AW-1:0] m_row [2];
  logic [2:0] e_red [2], e_grn [2];
  logic [1:0] e_blu [2];
  logic e_hs [2], e_vs [2];
  logic e_fs;

  logic [127:0] mem [2][16];
  int pend [2];
  logic prev_req [2];
  int dly_lo, dly_hi, skip_row, phase;
  logic ce_phase = 1'b0;
  int last_fs, hs_run;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int nh, nv, tgt;
    logic [7:0] c;
    logic pol;
    e_fs = 1'b0;
    px_ce = 1'b0;
    if (clr) begin
      m_h = 0; m_v = 0; pix_idx = 0;
      for (int k = 0; k < 2; k++) begin
        pol = (k == 1);
        m_req[k] = 0; m_fetched[k] = 0; m_fdata[k] = '0; m_active[k] = '0;
        m_row[k] = '0; m_ur[k] = 0;
        e_red[k] = 0; e_grn[k] = 0; e_blu[k] = 0; e_hs[k] = ~pol; e_vs[k] = ~pol;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ack_i[k] && m_req[k]) begin
          m_fetched[k] = 1'b1;
          m_fdata[k] = mem[k][m_row[k]];
          m_req[k] = 1'b0;
        end
      end
      if (pix_ce) begin
        px_ce = 1'b1; px_h = m_h; px_v = m_v; pix_idx++;
        for (int k = 0; k < 2; k++) begin
          pol = (k == 1);
          if (!(m_h < HA && m_v < VA)) c = 8'h00;
          else if (k == 0) c = m_active[0][m_h] ? mono_fg : mono_bg;
          else c = m_active[1][m_h*8 +: 8];
          e_red[k] = c[7:5]; e_grn[k] = c[4:2]; e_blu[k] = c[1:0];
          e_hs[k] = (m_h >= HA + HF && m_h < HA + HF + HS) ? pol : ~pol;
          e_vs[k] = (m_v >= VA + VF && m_v < VA + VF + VS) ? pol : ~pol;
        end
        e_fs = (m_h == 0 && m_v == 0);
        if (m_h == HA && (m_v < VA - 1 || m_v == VT - 1)) begin
          tgt = (m_v == VT - 1) ? 0 : m_v + 1;
          for (int k = 0; k < 2; k++) begin
            m_row[k] = 4'(tgt >> k);
            m_req[k] = 1'b1;
          end
        end
        nh = (m_h == HT - 1) ? 0 : m_h + 1;
        nv = m_v;
        if (m_h == HT - 1) nv = (m_v == VT - 1) ? 0 : m_v + 1;
        if (m_h == HT - 1 && nv < VA) begin
          for (int k = 0; k < 2; k++) begin
            if (m_fetched[k]) begin
              m_active[k] = m_fdata[k];
              m_fetched[k] = 1'b0;
            end else begin
              m_active[k] = '0;
              m_ur[k] = 1'b1;
              m_req[k] = 1'b0;
            end
          end
        end
        m_h = nh; m_v = nv;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("frame_start%0d", k), fs_o[k], e_fs);
      chk($sformatf("vram_req%0d", k), req_o[k], m_req[k]);
      if (m_req[k] && !m_req_prev[k]) chk($sformatf("vram_addr%0d", k), addr_o[k], m_row[k]);
      m_req_prev[k] = m_req[k];
      if (px_ce || clr) begin
        chk($sformatf("red%0d", k), red_o[k], e_red[k]);
        chk($sformatf("grn%0d", k), grn_o[k], e_grn[k]);
        chk($sformatf("blu%0d", k), blu_o[k], e_blu[k]);
        chk($sformatf("hsync%0d", k), hs_o[k], e_hs[k]);
        chk($sformatf("vsync%0d", k), vs_o[k], e_vs[k]);
        chk($sformatf("underrun%0d", k), ur_o[k], m_ur[k]);
      end
    end
    if (clr) begin
      last_fs = -1; hs_run = 0;
    end else begin
      if (fs_o[0]) begin
        if (last_fs >= 0) chk("frame_period", pix_idx - last_fs, HT * VT);
        last_fs = pix_idx;
      end
      if (px_ce) begin
        if (!hs_o[0]) hs_run++;
        else if (hs_run > 0) begin
          chk("hsync_width", hs_run, HS);
          hs_run = 0;
        end
        if (phase == 1 && px_v == 1 && px_h < HA)
          chk("mono_alt", red_o[0], (px_h % 2 == 1) ? 7 : 0);
        if (phase == 2 && px_v == 2 && px_h == 3) begin
          chk("px3_grn", grn_o[1], 7);
          chk("px3_red", red_o[1], 0);
        end
      end
    end
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      ack_i[k] = 1'b0;
      if (pend[k] > 0) begin
        pend[k]--;
        if (pend[k] == 0) begin
          ack_i[k] = 1'b1;
          pend[k] = -1;
        end
      end
    end
    vram_data_a = mem[0][addr_o[0]][15:0];
    vram_data_b = mem[1][addr_o[1]];
    pix_ce = ce_phase;
    ce_phase = ~ce_phase;
    @(posedge clk);
    #1;
    model_step();
    compare();
    for (int k = 0; k < 2; k++) begin
      if (req_o[k] && !prev_req[k])
        pend[k] = (k == 0 && int'(addr_o[0]) == skip_row) ? -1 : int'($urandom_range(dly_lo, dly_hi));
      else if (!req_o[k] && prev_req[k])
        pend[k] = -1;
      prev_req[k] = req_o[k];
    end
  endtask

  task automatic run_frames(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < 6 * HT * VT * n) begin
      cycle();
      if (e_fs) seen++;
      guard++;
    end
    if (seen < n) chk("frame_timeout", seen, n);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k] = -1; prev_req[k] = 0; m_req_prev[k] = 0; ack_i[k] = 0;
      for (int r = 0; r < 16; r++) mem[k][r] = {8{16'hAAAA}};
    end
    last_fs = -1; hs_run = 0; phase = 0;
    dly_lo = 3; dly_hi = 3; skip_row = -1;
    mono_fg = 8'hFF; mono_bg = 8'h00;
    clr = 1'b1;
    repeat (3) cycle();
    chk("rst_hsync_a", hs_o[0], 1);
    chk("rst_hsync_b", hs_o[1], 0);
    chk("rst_req_a", req_o[0], 0);
    chk("rst_red_a", red_o[0], 0);
    clr = 1'b0;

    phase = 1;
    run_frames(3);
    chk("ph1_underrun_a", ur_o[0], 0);

    phase = 2;
    mono_fg = 8'($urandom); mono_bg = 8'($urandom);
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 16; r++) mem[k][r] = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 0; r < 16; r++) mem[1][r][31:24] = 8'h1C;
    dly_lo = 1; dly_hi = 13;
    run_frames(1);

    phase = 3;
    dly_lo = 14; dly_hi = 14;
    run_frames(1);
    chk("ack_at_line_start_b", ur_o[1], 0);

    phase = 4;
    dly_lo = 1; dly_hi = 13; skip_row = 5;
    run_frames(1);
    skip_row = -1;
    chk("skip_underrun_a", ur_o[0], 1);
    run_frames(1);
    chk("sticky_underrun_a", ur_o[0], 1);

    phase = 5;
    mono_bg = 8'h00; dly_lo = 10; dly_hi = 10;
    begin
      int g = 0;
      while (!req_o[1] && g < 4 * HT) begin
        cycle();
        g++;
      end
      if (!req_o[1]) chk("req_timeout", req_o[1], 1);
    end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    pend[0] = -1; pend[1] = 2;
    cycle();
    cycle();
    chk("clr_req_b", req_o[1], 0);
    chk("clr_underrun_a", ur_o[0], 0);
    chk("clr_underrun_b", ur_o[1], 0);
    chk("clr_red_b", red_o[1], 0);
    chk("clr_hsync_b", hs_o[1], 0);
    dly_lo = 1; dly_hi = 13;
    run_frames(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
